prog_mem_stream: RTL and testbench

Parametrised program memory with a byte-stream loader, the next generation of the 12-bit/256-entry program store. Instruction width and depth are parameters. Words are loaded through a valid/ready byte stream by an auto-incrementing load FSM instead of a direct address/data write port. Instruction fetch is registered and blocked while a load is in progress. It sits between the boot/debug loader and the core's fetch stage.

---
 rtl/prog_mem_stream.sv | 130 +++++++++++++
 tb/tb_prog_mem_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_stream.sv
// prog_mem_stream: parametrised program memory loaded through an auto-incrementing byte-stream FSM.
// Define PROG_MEM_CSUM_EN to add a trailing check byte and the ld_csum/ld_csum_ok ports.
module prog_mem_stream #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [ADDR_W:0]   ld_count,
   input  logic [7:0]        ld_byte,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err
`ifdef PROG_MEM_CSUM_EN
   ,
   output logic [7:0]        ld_csum,
   output logic              ld_csum_ok
`endif
);
   localparam int BYTES = (DATA_W + 7) / 8;
   localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic [1:0] {IDLE, RECV, CHECK, DONE} state_t;
`ifdef PROG_MEM_CSUM_EN
   localparam state_t FIN = CHECK;
`else
   localparam state_t FIN = DONE;
`endif
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] asm_q, asm_d, asm_nx;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic instr_valid_q, instr_valid_d, err_q, err_d;
   logic we, xfer, start_ok, last_byte;
   logic [DATA_W-1:0] mem [DEPTH];
   assign xfer = ld_valid & ld_ready;
   assign start_ok = state_q == IDLE && ld_start && ld_count != '0;
   assign last_byte = idx_q == IDX_W'(BYTES - 1);
   assign ld_ready = state_q == RECV || state_q == CHECK;
   assign ld_busy = state_q != IDLE;
   assign ld_done = state_q == DONE;
   assign ld_err = err_q;
   assign instr = instr_q;
   assign instr_valid = instr_valid_q;
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      asm_d = asm_q;
      asm_nx = asm_q;
      we = 1'b0;
      err_d = ld_start && (state_q != IDLE || ld_count == '0);
      instr_valid_d = fetch_en & ~ld_busy;
      instr_d = instr_valid_d ? mem[fetch_addr] : '0;
      // Little-endian lane insert; bits past DATA_W in the top byte fall away
      for (int i = 0; i < DATA_W; i++)
         if (IDX_W'(i / 8) == idx_q) asm_nx[i] = ld_byte[i % 8];
      if (start_ok) begin
         state_d = RECV;
         addr_d = ld_base;
         cnt_d = ld_count;
         idx_d = '0;
         asm_d = '0;
      end
      if (state_q == RECV && xfer) begin
         asm_d = last_byte ? '0 : asm_nx;
         idx_d = last_byte ? '0 : idx_q + 1'b1;
         we = last_byte;
         addr_d = last_byte ? addr_q + 1'b1 : addr_q;
         cnt_d = last_byte ? cnt_q - 1'b1 : cnt_q;
         state_d = last_byte && cnt_q == (ADDR_W + 1)'(1) ? FIN : RECV;
      end
      if (state_q == CHECK && xfer) state_d = DONE;
      if (state_q == DONE) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q <= '0;
         cnt_q <= '0;
         idx_q <= '0;
         asm_q <= '0;
         instr_q <= '0;
         instr_valid_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         asm_q <= asm_d;
         instr_q <= instr_d;
         instr_valid_q <= instr_valid_d;
         err_q <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (we) mem[addr_q] <= asm_nx;
   end
`ifdef PROG_MEM_CSUM_EN
   logic [7:0] csum_q, csum_d;
   logic ok_q, ok_d;
   always_comb begin
      csum_d = start_ok ? 8'h00 : xfer ? csum_q + ld_byte : csum_q;
      ok_d = start_ok ? 1'b0 : (state_q == CHECK && xfer) ? csum_d == 8'h00 : ok_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= 8'h00;
         ok_q <= 1'b0;
      end else begin
         csum_q <= csum_d;
         ok_q <= ok_d;
      end
   end
   assign ld_csum = csum_q;
   assign ld_csum_ok = ok_q;
`endif
endmodule

// File: tb/tb_prog_mem_stream.sv
// tb_prog_mem_stream: directed stimulus with a queue scoreboard for fetches, done and err pulses.
module tb_prog_mem_stream;
   logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, ld_start = 1'b0, ld_valid = 1'b0;
   logic [7:0] fetch_addr = '0, ld_base = '0, ld_byte = '0;
   logic [8:0] ld_count = '0;
   logic [11:0] instr;
   logic instr_valid, ld_ready, ld_busy, ld_done, ld_err;
`ifdef PROG_MEM_CSUM_EN
   logic [7:0] ld_csum;
   logic ld_csum_ok;
`endif
   int total = 0, passed = 0, err_pend = 0;
   logic [11:0] fq[$];
   bit dq[$];
   logic [7:0] sum = '0;
   always #5 clk = ~clk;
   prog_mem_stream dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .instr(instr), .instr_valid(instr_valid), .ld_start(ld_start), .ld_base(ld_base),
      .ld_count(ld_count), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
`ifdef PROG_MEM_CSUM_EN
      , .ld_csum(ld_csum), .ld_csum_ok(ld_csum_ok)
`endif
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         if (instr_valid) begin
            chk("fetch_expected", fq.size() != 0, 1);
            if (fq.size() != 0) chk("fetch_instr", instr, fq.pop_front());
         end
         if (ld_done) begin
            chk("done_expected", dq.size() != 0, 1);
            if (dq.size() != 0) begin
`ifdef PROG_MEM_CSUM_EN
               chk("csum_ok", ld_csum_ok, dq.pop_front());
`else
               void'(dq.pop_front());
`endif
            end
         end
         if (ld_err) begin
            chk("err_expected", err_pend > 0, 1);
            if (err_pend > 0) err_pend--;
         end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic fetch(input logic [7:0] a, input logic [11:0] e);
      fetch_en = 1'b1;
      fetch_addr = a;
      fq.push_back(e);
      tick;
      fetch_en = 1'b0;
   endtask
   task automatic start(input logic [7:0] base, input logic [8:0] cnt, input bit rej);
      ld_start = 1'b1;
      ld_base = base;
      ld_count = cnt;
      if (rej) err_pend++;
      tick;
      ld_start = 1'b0;
      if (!rej) sum = '0;
   endtask
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      ld_byte = b;
      ld_valid = 1'b1;
      while (!ld_ready && n < 20) begin
         tick;
         n++;
      end
      if (!ld_ready) chk("ready_timeout", 0, 1);
      tick;
      ld_valid = 1'b0;
      sum = sum + b;
   endtask
   task automatic finish(input bit bad);
`ifdef PROG_MEM_CSUM_EN
      logic [7:0] c;
      c = 8'h00 - sum + {7'd0, bad};
      send_byte(c);
`endif
      dq.push_back(!bad);
      chk("done_latency", ld_done, 1);
      chk("ready_low", ld_ready, 0);
      tick;
      chk("busy_fall", ld_busy, 0);
   endtask
   task automatic load(input logic [7:0] base, input logic [8:0] cnt, input logic [31:0] data,
                       input int gap, input bit bad);
      start(base, cnt, 0);
      for (int i = 0; i < int'(cnt) * 2; i++) begin
         send_byte(data[i*8 +: 8]);
         if (i < int'(cnt) * 2 - 1) repeat (gap) tick;
      end
      finish(bad);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
   initial begin
      tick;
      tick;
      chk("rst_instr", instr, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_busy", ld_busy, 0);
      chk("rst_done", ld_done, 0);
      chk("rst_err", ld_err, 0);
`ifdef PROG_MEM_CSUM_EN
      chk("rst_csum", ld_csum, 0);
      chk("rst_csum_ok", ld_csum_ok, 0);
`endif
      rst = 1'b0;
      tick;
      load(8'h10, 9'd2, 32'h0ACD_F234, 0, 0);
      fetch(8'h10, 12'h234);
      fetch(8'h11, 12'hACD);
`ifdef PROG_MEM_CSUM_EN
      load(8'h10, 9'd2, 32'h0ACD_F234, 0, 1);
`endif
      load(8'h01, 9'd1, 32'h0000_0555, 0, 0);
      load(8'hFF, 9'd2, 32'h0CAB_0F0F, 0, 0);
      fetch(8'hFF, 12'hF0F);
      fetch(8'h00, 12'hCAB);
      fetch(8'h01, 12'h555);
      start(8'h10, 9'd0, 1);
      chk("zero_count_busy", ld_busy, 0);
      tick;
      fetch(8'h10, 12'h234);
      fetch_en = 1'b1;
      fetch_addr = 8'h10;
      fq.push_back(12'h234);
      start(8'h40, 9'd2, 0);
      send_byte(8'h11);
      chk("fetch_blocked_valid", instr_valid, 0);
      chk("fetch_blocked_instr", instr, 0);
      fetch_en = 1'b0;
      ld_start = 1'b1;
      ld_base = 8'h80;
      ld_count = 9'd5;
      err_pend++;
      send_byte(8'h01);
      ld_start = 1'b0;
      send_byte(8'h22);
      send_byte(8'h02);
      finish(0);
      fetch(8'h40, 12'h111);
      fetch(8'h41, 12'h222);
      load(8'h30, 9'd2, 32'h0ACD_F234, 2, 0);
      fetch(8'h30, 12'h234);
      fetch(8'h31, 12'hACD);
      load(8'h51, 9'd1, 32'h0000_0666, 0, 0);
      start(8'h50, 9'd2, 0);
      send_byte(8'h21);
      send_byte(8'h03);
      send_byte(8'h77);
      rst = 1'b1;
      tick;
      tick;
      chk("midrst_busy", ld_busy, 0);
      chk("midrst_ready", ld_ready, 0);
`ifdef PROG_MEM_CSUM_EN
      chk("midrst_csum", ld_csum, 0);
`endif
      rst = 1'b0;
      tick;
      fetch(8'h50, 12'h321);
      fetch(8'h51, 12'h666);
      repeat (3) tick;
      chk("scoreboard_drained", fq.size() + dq.size() + err_pend, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
